// File: rtl/four_bank_mem_responder_if.sv
// Request/response bundle between the cache controller and the four-bank memory responder.
// Master drives requests; slave returns read data, stall, err and per-bank busy flags.
interface four_bank_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              stall;
    logic              err;
    logic [3:0]        busy;

    modport master (
        output rd, wr, addr, data_in,
        input  data_out, rd_valid, stall, err, busy
    );

    modport slave (
        input  rd, wr, addr, data_in,
        output data_out, rd_valid, stall, err, busy
    );
endinterface

// File: rtl/four_bank_mem_responder.sv
// Word-interleaved four-bank memory responder with a fixed 2-cycle read latency.
// Bank occupancy tracking and stalling are built only when MEM_BANK_CONFLICT_EN is defined.
module four_bank_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 32768,
    parameter int BANK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    four_bank_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx_s;
    logic              req_s;
    logic              err_s;
    logic              legal_s;
    logic              stall_s;
    logic              accept_s;
    logic [3:0]        busy_s;
    logic              v1_r;
    logic [DATA_W-1:0] d1_r;
    logic              rd_valid_r;
    logic [DATA_W-1:0] data_out_r;

    // Truncation to IDX_W bits gives the modulo-DEPTH_WORDS wrap.
    assign idx_s = IDX_W'(bus.addr[ADDR_W-1:1]);

`ifdef MEM_BANK_CONFLICT_EN
    localparam int CNT_W = (BANK_CYCLES > 1) ? $clog2(BANK_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r [4];
    logic [1:0]       bank_s;

    assign bank_s = bus.addr[2:1];

    // Per-bank occupancy down-counters, reloaded on every accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept_s && (bank_s == 2'(i))) begin
                    cnt_r[i] <= CNT_W'(BANK_CYCLES - 1);
                end else if (cnt_r[i] != '0) begin
                    cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end
            end
        end
    end

    // Busy flags decode straight from the counter registers.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            busy_s[i] = (cnt_r[i] != '0);
        end
    end
`else
    assign busy_s = 4'b0000;
`endif

    // Request legality, bank conflict and accept decode.
    always_comb begin
        req_s   = bus.rd | bus.wr;
        err_s   = (bus.rd & bus.wr) | (req_s & bus.addr[0]);
        legal_s = req_s & ~err_s;
`ifdef MEM_BANK_CONFLICT_EN
        stall_s = legal_s & busy_s[bank_s];
`else
        stall_s = 1'b0;
`endif
        accept_s = legal_s & ~stall_s & rst;
    end

    // Backing storage and first read stage; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept_s && bus.wr) begin
            mem_r[idx_s] <= bus.data_in;
        end
        if (accept_s && bus.rd) begin
            d1_r <= mem_r[idx_s];
        end
    end

    // Read pipeline valids and the output register; data_out holds between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_r       <= 1'b0;
            rd_valid_r <= 1'b0;
            data_out_r <= '0;
        end else begin
            v1_r       <= accept_s & bus.rd;
            rd_valid_r <= v1_r;
            if (v1_r) begin
                data_out_r <= d1_r;
            end
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.stall    = stall_s;
    assign bus.err      = err_s;
    assign bus.busy     = busy_s;
endmodule

// File: doc/four_bank_mem_responder.md
Name: four_bank_mem_responder

Overview:
- Memory-side responder for the cache controller's line fill and write-back bursts.
- Word-interleaved main memory with four banks. Accepts one word read or write per cycle and returns read data with a fixed 2-cycle latency.
- Stalls the requester when the target bank is still busy from an earlier access.
- Sits between the cache controller's read_mem/write_mem/mem_addr outputs and its mem_stall input.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- DEPTH_WORDS, 32768, words of backing storage (addr[ADDR_W-1:1] indexes it).
- BANK_CYCLES, 4, cycles a bank stays occupied per access, including the accept cycle.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- rd  input  1  read request.
- wr  input  1  write request.
- addr  input  ADDR_W  byte address; bank = addr[2:1].
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  read data, registered.
- rd_valid  output  1  one-cycle pulse: data_out holds accepted read data.
- stall  output  1  request not accepted this cycle, bank busy (combinational).
- err  output  1  illegal request dropped this cycle (combinational).
- busy  output  4  per-bank occupied flags, registered.

Behaviour:
- Reset (rst==0 at a clk edge):
  - data_out=0, rd_valid=0, busy=4'b0000.
  - All bank counters cleared; the read pipeline is flushed.
  - Storage contents are not reset.
- Legal request: exactly one of rd/wr high, and addr[0]==0.
- err=1 when rd&wr, or when (rd|wr)&addr[0]. The request is ignored: no storage update, no busy change, no rd_valid. stall=0 whenever err=1.
- stall=1 when a legal request targets bank b and busy[b]==1. No side effects; the requester holds rd/wr/addr/data_in stable and retries.
- Accept when the request is legal and busy[b]==0.
- Write accepted in cycle t:
  - mem[addr[ADDR_W-1:1]] <= data_in at the edge ending cycle t.
  - Bank b is busy during cycles t+1 .. t+BANK_CYCLES-1.
- Read accepted in cycle t:
  - The word is sampled at the edge ending cycle t and passes one pipeline register.
  - data_out/rd_valid are presented during cycle t+2.
  - Bank busy timing is the same as for writes.
- Bank timing:
  - Each bank has a down-counter of width clog2(BANK_CYCLES), loaded with BANK_CYCLES-1 on accept and decremented to 0.
  - busy[b] = (counter_b != 0).
  - Four consecutive accesses to banks 0,1,2,3 never stall. The same bank may be re-accepted in cycle t+BANK_CYCLES.
- Read pipeline:
  - Two stages, each holding {valid, data}. At most two reads are in flight.
  - One read may be accepted per cycle, so rd_valid may be high on consecutive cycles.
  - data_out holds its last value when rd_valid=0.
- Ordering:
  - Reads return in accept order.
  - A read accepted after a write to the same word (necessarily >= BANK_CYCLES later) returns the written data.
- Reset while reads are in flight: the reads are discarded and no rd_valid follows deassertion of rst.
- Idle (rd=wr=0): stall=0, err=0, and counters keep decrementing.
- Address wrap: only addr[ADDR_W-1:1] modulo DEPTH_WORDS is used. The top address 16'hFFFE is a legal word.

Optional Feature:
- Macro: MEM_BANK_CONFLICT_EN.
- Defined: bank counters, busy flags and stall behave as described above.
- Undefined:
  - No bank tracking; busy is tied to 4'b0000 and stall to 0.
  - Every legal request is accepted the cycle it is presented.
  - Read latency (2 cycles), err behaviour and storage behaviour are unchanged.

Test Plan:
- Write 4-word line at 16'h1230,16'h1232,16'h1234,16'h1236 (data A0..A3) on consecutive cycles; then read it back on four consecutive cycles. Required: no stall; rd_valid high in cycles 2..5 after the first read; data_out = A0,A1,A2,A3 in order.
- Write 16'h0008, then write 16'h0010 next cycle (both bank 0). Required: stall=1 for 3 cycles, second write accepted in cycle 4, busy[0] high throughout. With MEM_BANK_CONFLICT_EN undefined: no stall, and both words are written.
- Assert rd=1 and wr=1 at 16'h0004; separately, rd at odd addr 16'h0005. Required: err=1 and stall=0 for both, no rd_valid, storage at word 16'h0004 unchanged.
- Accept read at 16'h0020, then drop rst to 0 the next cycle for one cycle. Required: no rd_valid appears afterwards; data_out=0 and busy=0 after reset.
- Write 16'hBEEF to 16'hFFFE, then read 16'hFFFE. Required: data_out=16'hBEEF with rd_valid exactly 2 cycles after the read is accepted.
- Back-to-back reads to banks 1 and 2 while a bank 1 write is still busy. Required: the bank 1 read stalls until busy[1] clears; the bank 2 read is then accepted without stalling; the two results return in accept order.
